// File: rtl/sha2_block_engine_if.sv
// Block-level handshake between a SHA-2 driver (padding/sequencing) and the compression engine.
interface sha2_block_engine_if;
    logic         start;
    logic         first;
    logic         mode;
    logic [31:0]  w_data;
    logic         w_valid;
    logic         w_ready;
    logic         busy;
    logic         done;
    logic         digest_valid;
    logic [255:0] digest;

    modport master (
        output start, first, mode, w_data, w_valid,
        input  w_ready, busy, done, digest_valid, digest
    );

    modport slave (
        input  start, first, mode, w_data, w_valid,
        output w_ready, busy, done, digest_valid, digest
    );
endinterface

// File: rtl/sha2_block_engine.sv
// SHA-224/SHA-256 compression engine: streams one pre-padded block, runs 64 rounds
// ROUNDS_PER_CYCLE at a time, folds the result into the chaining value.
module sha2_block_engine #(
    parameter int unsigned ROUNDS_PER_CYCLE = 1
) (
    input  logic                clk,
    input  logic                reset,
    sha2_block_engine_if.slave  bus
);

    localparam int unsigned WORD_W   = 32;
    localparam int unsigned N_ROUNDS = 64;
    localparam int unsigned CNT_W    = 4;
    localparam int unsigned RND_W    = 6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ROUND,
        S_ADD,
        S_DONE
    } state_e;

    localparam logic [WORD_W-1:0] KVALS [N_ROUNDS] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [WORD_W-1:0] IV256 [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [WORD_W-1:0] IV224 [8] = '{
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
    };

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int unsigned n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic logic [WORD_W-1:0] bsig0(input logic [WORD_W-1:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [WORD_W-1:0] bsig1(input logic [WORD_W-1:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [WORD_W-1:0] ssig0(input logic [WORD_W-1:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [WORD_W-1:0] ssig1(input logic [WORD_W-1:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [WORD_W-1:0] ch(input logic [WORD_W-1:0] e, input logic [WORD_W-1:0] f,
                                             input logic [WORD_W-1:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [WORD_W-1:0] maj(input logic [WORD_W-1:0] a, input logic [WORD_W-1:0] b,
                                              input logic [WORD_W-1:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    state_e                   state_q, state_d;
    logic                     mode_q, mode_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [RND_W-1:0]         round_q, round_d;
    logic [7:0][WORD_W-1:0]   h_q, h_d;        // index 0 = H0
    logic [7:0][WORD_W-1:0]   work_q, work_d;  // index 0 = a .. 7 = h
    logic [15:0][WORD_W-1:0]  w_q, w_d;        // w_q[0] = W[t]
    logic [255:0]             digest_q, digest_d;
    logic                     dv_q, dv_d;
    logic                     busy_q, w_ready_q, done_q;

    // Combinational round chain scratch
    logic [15:0][WORD_W-1:0]  wv;
    logic [7:0][WORD_W-1:0]   st;
    logic [WORD_W-1:0]        t1, t2, nw;
    logic [RND_W-1:0]         ridx;

    assign bus.w_ready      = w_ready_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.digest_valid = dv_q;
    assign bus.digest       = digest_q;

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        cnt_d    = cnt_q;
        round_d  = round_q;
        h_d      = h_q;
        work_d   = work_q;
        w_d      = w_q;
        digest_d = digest_q;
        dv_d     = dv_q;
        wv       = w_q;
        st       = work_q;
        t1       = '0;
        t2       = '0;
        nw       = '0;
        ridx     = round_q;

        // R chained rounds; the window always produces W[t+16] so early rounds need no special case
        for (int r = 0; r < int'(ROUNDS_PER_CYCLE); r++) begin
            ridx = round_q + RND_W'(r);
            t1   = st[7] + bsig1(st[4]) + ch(st[4], st[5], st[6]) + KVALS[ridx] + wv[0];
            t2   = bsig0(st[0]) + maj(st[0], st[1], st[2]);
            nw   = ssig1(wv[14]) + wv[9] + ssig0(wv[1]) + wv[0];
            st   = {st[6:0], t1 + t2};
            st[4] = st[4] + t1;
            wv   = {nw, wv[15:1]};
        end

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.first) begin
                        mode_d = bus.mode;
                        for (int i = 0; i < 8; i++) begin
                            h_d[i] = bus.mode ? IV224[i] : IV256[i];
                        end
                    end
                    work_d  = h_d;
                    cnt_d   = '0;
                    round_d = '0;
                    dv_d    = 1'b0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (bus.w_valid && w_ready_q) begin
                    w_d[cnt_q] = bus.w_data;
                    cnt_d      = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(15)) begin
                        state_d = S_ROUND;
                    end
                end
            end
            S_ROUND: begin
                work_d  = st;
                w_d     = wv;
                round_d = round_q + RND_W'(ROUNDS_PER_CYCLE);
                if (round_q == RND_W'(N_ROUNDS - ROUNDS_PER_CYCLE)) begin
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                // Digest is loaded alongside H so it is valid in the same cycle done pulses
                for (int i = 0; i < 8; i++) begin
                    h_d[i] = h_q[i] + work_q[i];
                    digest_d[255 - 32*i -: 32] = h_d[i];
                end
                if (mode_q) begin
                    digest_d[31:0] = '0;
                end
                dv_d    = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            mode_q    <= 1'b0;
            cnt_q     <= '0;
            round_q   <= '0;
            h_q       <= '0;
            work_q    <= '0;
            w_q       <= '0;
            digest_q  <= '0;
            dv_q      <= 1'b0;
            busy_q    <= 1'b0;
            w_ready_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            cnt_q     <= cnt_d;
            round_q   <= round_d;
            h_q       <= h_d;
            work_q    <= work_d;
            w_q       <= w_d;
            digest_q  <= digest_d;
            dv_q      <= dv_d;
            busy_q    <= (state_d != S_IDLE);
            w_ready_q <= (state_d == S_LOAD);
            done_q    <= (state_d == S_DONE);
        end
    end

endmodule

// File: tb/tb_sha2_block_engine.sv
// Directed bench for sha2_block_engine: known-answer digests, latency, backpressure,
// back-to-back chaining, R=4 build and abort by reset.
module tb_sha2_block_engine;

    localparam logic [255:0] ABC256 =
        256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] ABC224 =
        256'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7_00000000;
    localparam logic [255:0] TWO256 =
        256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

    logic clk = 1'b0;
    logic reset_r = 1'b1;
    logic sel = 1'b0;  // 0 drives/observes the R=1 instance, 1 the R=4 instance
    logic start_r = 1'b0, first_r = 1'b0, mode_r = 1'b0, w_valid_r = 1'b0;
    logic [31:0] w_data_r = '0;

    int n_cmp = 0;
    int n_fail = 0;

    logic [15:0][31:0] msg_abc, msg_b1, msg_b2;

    always #5 clk = ~clk;

    sha2_block_engine_if bus1 ();
    sha2_block_engine_if bus4 ();

    assign bus1.start   = (sel == 1'b0) ? start_r : 1'b0;
    assign bus1.first   = first_r;
    assign bus1.mode    = mode_r;
    assign bus1.w_data  = w_data_r;
    assign bus1.w_valid = (sel == 1'b0) ? w_valid_r : 1'b0;
    assign bus4.start   = (sel == 1'b1) ? start_r : 1'b0;
    assign bus4.first   = first_r;
    assign bus4.mode    = mode_r;
    assign bus4.w_data  = w_data_r;
    assign bus4.w_valid = (sel == 1'b1) ? w_valid_r : 1'b0;

    sha2_block_engine #(.ROUNDS_PER_CYCLE(1)) u_dut1 (.clk(clk), .reset(reset_r), .bus(bus1));
    sha2_block_engine #(.ROUNDS_PER_CYCLE(4)) u_dut4 (.clk(clk), .reset(reset_r), .bus(bus4));

    wire         o_w_ready = sel ? bus4.w_ready      : bus1.w_ready;
    wire         o_busy    = sel ? bus4.busy         : bus1.busy;
    wire         o_done    = sel ? bus4.done         : bus1.done;
    wire         o_dv      = sel ? bus4.digest_valid : bus1.digest_valid;
    wire [255:0] o_digest  = sel ? bus4.digest       : bus1.digest;

    // Start at edge 0, stream words on w_ready (optionally stalling every third LOAD cycle),
    // and report what was seen in cycle 1 and in the done cycle (-1 if done never came).
    task automatic run_block(input logic [15:0][31:0] blk, input logic fst, input logic md,
                             input bit stall, output int done_cyc, output logic [255:0] dig,
                             output logic dv_done, output logic busy_done,
                             output logic dv_c1, output logic [255:0] dig_c1);
        int idx = 0;
        int k = 0;
        done_cyc = -1; dig = '0; dv_done = 1'b0; busy_done = 1'b0; dv_c1 = 1'b1; dig_c1 = '0;
        @(negedge clk);
        start_r = 1'b1; first_r = fst; mode_r = md; w_valid_r = 1'b0;
        for (int c = 1; c <= 200 && done_cyc < 0; c++) begin
            @(negedge clk);
            start_r = 1'b0;
            if (c == 1) begin
                dv_c1 = o_dv; dig_c1 = o_digest;
            end
            if (o_done === 1'b1) begin
                done_cyc = c; dig = o_digest; dv_done = o_dv; busy_done = o_busy;
            end
            w_valid_r = 1'b0;
            if (o_w_ready === 1'b1 && idx < 16) begin
                if (!(stall && (k % 3 == 0))) begin
                    w_valid_r = 1'b1; w_data_r = blk[idx]; idx++;
                end
                k++;
            end
        end
        w_valid_r = 1'b0;
    endtask

    task automatic test_reset();
        reset_r = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_r = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus1.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy_r1: got %b want 0", bus1.busy); end
        n_cmp++; if (bus1.w_ready !== 1'b0) begin n_fail++; $display("FAIL reset_w_ready_r1: got %b want 0", bus1.w_ready); end
        n_cmp++; if (bus1.done !== 1'b0) begin n_fail++; $display("FAIL reset_done_r1: got %b want 0", bus1.done); end
        n_cmp++; if (bus1.digest_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dv_r1: got %b want 0", bus1.digest_valid); end
        n_cmp++; if (bus4.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy_r4: got %b want 0", bus4.busy); end
        n_cmp++; if (bus4.digest_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dv_r4: got %b want 0", bus4.digest_valid); end
    endtask

    task automatic test_sha256_abc();
        int dc; logic [255:0] dg, dg1; logic dvd, bd, dv1;
        sel = 1'b0;
        run_block(msg_abc, 1'b1, 1'b0, 1'b0, dc, dg, dvd, bd, dv1, dg1);
        n_cmp++; if (dc !== 82) begin n_fail++; $display("FAIL sha256_done_cycle: got %0d want 82", dc); end
        n_cmp++; if (dg !== ABC256) begin n_fail++; $display("FAIL sha256_digest: got %h want %h", dg, ABC256); end
        n_cmp++; if (dvd !== 1'b1) begin n_fail++; $display("FAIL sha256_dv_at_done: got %b want 1", dvd); end
        n_cmp++; if (bd !== 1'b1) begin n_fail++; $display("FAIL sha256_busy_at_done: got %b want 1", bd); end
        n_cmp++; if (dv1 !== 1'b0) begin n_fail++; $display("FAIL sha256_dv_cycle1: got %b want 0", dv1); end
        @(negedge clk);
        n_cmp++; if (o_done !== 1'b0) begin n_fail++; $display("FAIL sha256_done_pulse_width: got %b want 0", o_done); end
        n_cmp++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL sha256_idle_after_done: busy got %b want 0", o_busy); end
        n_cmp++; if (o_dv !== 1'b1) begin n_fail++; $display("FAIL sha256_dv_held: got %b want 1", o_dv); end
    endtask

    task automatic test_sha224_abc();
        int dc; logic [255:0] dg, dg1; logic dvd, bd, dv1;
        sel = 1'b0;
        run_block(msg_abc, 1'b1, 1'b1, 1'b0, dc, dg, dvd, bd, dv1, dg1);
        n_cmp++; if (dc !== 82) begin n_fail++; $display("FAIL sha224_done_cycle: got %0d want 82", dc); end
        n_cmp++; if (dg !== ABC224) begin n_fail++; $display("FAIL sha224_digest: got %h want %h", dg, ABC224); end
        n_cmp++; if (dg1 !== ABC256) begin n_fail++; $display("FAIL sha224_prev_digest_stable: got %h want %h", dg1, ABC256); end
        n_cmp++; if (dv1 !== 1'b0) begin n_fail++; $display("FAIL sha224_dv_cleared_on_start: got %b want 0", dv1); end
    endtask

    task automatic test_back_to_back(input logic s, input int lat);
        int dc; logic [255:0] dg, dg1; logic dvd, bd, dv1;
        sel = s;
        run_block(msg_b1, 1'b1, 1'b0, 1'b0, dc, dg, dvd, bd, dv1, dg1);
        n_cmp++; if (dc !== lat) begin n_fail++; $display("FAIL b2b_blk1_done_cycle_sel%0d: got %0d want %0d", s, dc, lat); end
        run_block(msg_b2, 1'b0, 1'b1, 1'b0, dc, dg, dvd, bd, dv1, dg1);
        n_cmp++; if (dc !== lat) begin n_fail++; $display("FAIL b2b_blk2_done_cycle_sel%0d: got %0d want %0d", s, dc, lat); end
        n_cmp++; if (dg !== TWO256) begin n_fail++; $display("FAIL b2b_digest_sel%0d: got %h want %h", s, dg, TWO256); end
    endtask

    task automatic test_backpressure();
        int dc; logic [255:0] dg, dg1; logic dvd, bd, dv1;
        sel = 1'b0;
        run_block(msg_abc, 1'b1, 1'b0, 1'b1, dc, dg, dvd, bd, dv1, dg1);
        n_cmp++; if (dc !== 90) begin n_fail++; $display("FAIL bp_done_cycle: got %0d want 90", dc); end
        n_cmp++; if (dg !== ABC256) begin n_fail++; $display("FAIL bp_digest: got %h want %h", dg, ABC256); end
    endtask

    task automatic test_r4();
        int dc; logic [255:0] dg, dg1; logic dvd, bd, dv1;
        sel = 1'b1;
        run_block(msg_abc, 1'b1, 1'b0, 1'b0, dc, dg, dvd, bd, dv1, dg1);
        n_cmp++; if (dc !== 34) begin n_fail++; $display("FAIL r4_done_cycle: got %0d want 34", dc); end
        n_cmp++; if (dg !== ABC256) begin n_fail++; $display("FAIL r4_digest: got %h want %h", dg, ABC256); end
        run_block(msg_abc, 1'b1, 1'b1, 1'b0, dc, dg, dvd, bd, dv1, dg1);
        n_cmp++; if (dg !== ABC224) begin n_fail++; $display("FAIL r4_sha224_digest: got %h want %h", dg, ABC224); end
        test_back_to_back(1'b1, 34);
    endtask

    task automatic test_abort();
        int idx = 0;
        bit saw_done = 1'b0;
        int dc; logic [255:0] dg, dg1; logic dvd, bd, dv1;
        sel = 1'b0;
        @(negedge clk);
        start_r = 1'b1; first_r = 1'b1; mode_r = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            start_r = (c == 40);
            reset_r = (c == 50);
            if (o_done === 1'b1) saw_done = 1'b1;
            if (c == 45) begin
                n_cmp++; if (o_w_ready !== 1'b0) begin n_fail++; $display("FAIL abort_start_ignored: w_ready got %b want 0", o_w_ready); end
                n_cmp++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy_before_reset: got %b want 1", o_busy); end
            end
            if (c == 51) begin
                n_cmp++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy_after_reset: got %b want 0", o_busy); end
                n_cmp++; if (o_dv !== 1'b0) begin n_fail++; $display("FAIL abort_dv_after_reset: got %b want 0", o_dv); end
            end
            w_valid_r = 1'b0;
            if (o_w_ready === 1'b1 && idx < 16) begin
                w_valid_r = 1'b1; w_data_r = msg_abc[idx]; idx++;
            end
        end
        start_r = 1'b0; reset_r = 1'b0; w_valid_r = 1'b0;
        n_cmp++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL abort_no_done: saw done %b want 0", saw_done); end
        run_block(msg_abc, 1'b1, 1'b0, 1'b0, dc, dg, dvd, bd, dv1, dg1);
        n_cmp++; if (dc !== 82) begin n_fail++; $display("FAIL abort_rerun_done_cycle: got %0d want 82", dc); end
        n_cmp++; if (dg !== ABC256) begin n_fail++; $display("FAIL abort_rerun_digest: got %h want %h", dg, ABC256); end
    endtask

    initial begin
        msg_abc = '0;
        msg_abc[0]  = 32'h61626380;
        msg_abc[15] = 32'h00000018;
        msg_b1[0]  = 32'h61626364; msg_b1[1]  = 32'h62636465; msg_b1[2]  = 32'h63646566; msg_b1[3]  = 32'h64656667;
        msg_b1[4]  = 32'h65666768; msg_b1[5]  = 32'h66676869; msg_b1[6]  = 32'h6768696a; msg_b1[7]  = 32'h68696a6b;
        msg_b1[8]  = 32'h696a6b6c; msg_b1[9]  = 32'h6a6b6c6d; msg_b1[10] = 32'h6b6c6d6e; msg_b1[11] = 32'h6c6d6e6f;
        msg_b1[12] = 32'h6d6e6f70; msg_b1[13] = 32'h6e6f7071; msg_b1[14] = 32'h80000000; msg_b1[15] = 32'h00000000;
        msg_b2 = '0;
        msg_b2[15] = 32'h000001c0;

        test_reset();
        test_sha256_abc();
        test_sha224_abc();
        test_back_to_back(1'b0, 82);
        test_backpressure();
        test_r4();
        test_abort();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
